// File: rtl/cluster_pkt_ring_alloc.sv
// Ring-organized packet-buffer allocator: hands out slot-aligned contiguous regions and frees them in any order.
// Outputs are combinational from state and alloc_size_i; alloc/free commit at the clock edge. Upstream must hold requests until alloc_ready_o.
module cluster_pkt_ring_alloc #(
  parameter int unsigned BuffMemLength = 512,
  parameter int unsigned MemSlotSize   = 64,
  localparam int unsigned SW = $clog2(BuffMemLength) + 1,
  localparam int unsigned IW = $clog2(BuffMemLength)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          alloc_valid_i,
  output logic          alloc_ready_o,
  input  logic [SW-1:0] alloc_size_i,
  output logic [IW-1:0] alloc_index_o,
  input  logic          free_valid_i,
  input  logic [IW-1:0] free_index_i,
  input  logic [SW-1:0] free_size_i,
  output logic [SW-1:0] free_space_o
);

  localparam int unsigned NumSlots = BuffMemLength / MemSlotSize;
  localparam int unsigned SB       = $clog2(MemSlotSize);
  localparam int unsigned HW       = IW - SB;

  logic [NumSlots-1:0] busy_q;
  logic [HW-1:0]       head_q;

  logic [SW:0]         n_slots, nf_slots;
  logic [HW-1:0]       fs, tail, start;
  logic [HW:0]         to_end, avail;
  logic                empty, found;
  logic [NumSlots-1:0] alloc_mask, free_mask;
  logic                do_alloc, do_free;

  assign n_slots  = ({1'b0, alloc_size_i} + (SW+1)'(MemSlotSize - 1)) >> SB;
  assign nf_slots = ({1'b0, free_size_i}  + (SW+1)'(MemSlotSize - 1)) >> SB;
  assign fs       = free_index_i[IW-1:SB];
  assign empty    = ~|busy_q;
  assign to_end   = (HW+1)'(NumSlots) - {1'b0, head_q};

  // Oldest live region: first busy slot at or after head, wrapping around.
  always_comb begin
    logic [HW:0] sum;
    tail  = head_q;
    found = 1'b0;
    for (int i = 0; i < NumSlots; i++) begin
      sum = {1'b0, head_q} + (HW+1)'(i);
      if (!found && busy_q[sum[HW-1:0]]) begin
        tail  = sum[HW-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    avail = '0;
    start = head_q;
    if (empty) begin
      avail = (HW+1)'(NumSlots);
      start = '0;
    end else if (head_q > tail) begin
      avail = (to_end > {1'b0, tail}) ? to_end : {1'b0, tail};
      // A request too long for the run up to the end wraps to slot 0; the skipped tail slots stay free.
      start = (n_slots <= (SW+1)'(to_end)) ? head_q : '0;
    end else if (head_q < tail) begin
      avail = {1'b0, tail} - {1'b0, head_q};
    end
  end

  assign free_space_o  = {avail, {SB{1'b0}}};
  assign alloc_ready_o = n_slots <= (SW+1)'(avail);
  assign alloc_index_o = {start, {SB{1'b0}}};

  assign do_alloc = alloc_valid_i && alloc_ready_o && (n_slots != '0);
  assign do_free  = free_valid_i && (nf_slots != '0);

  always_comb begin
    for (int i = 0; i < NumSlots; i++) begin
      alloc_mask[i] = (i >= int'(start)) && (i < int'(start) + int'(n_slots));
      free_mask[i]  = (i >= int'(fs))    && (i < int'(fs) + int'(nf_slots));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q <= '0;
      head_q <= '0;
    end else begin
      busy_q <= (busy_q | (do_alloc ? alloc_mask : '0)) & ~(do_free ? free_mask : '0);
      if (do_alloc) head_q <= start + n_slots[HW-1:0];
    end
  end

endmodule

// File: tb/tb_cluster_pkt_ring_alloc.sv
// Directed bench for cluster_pkt_ring_alloc with a cycle-tagged expectation scoreboard.
module tb_cluster_pkt_ring_alloc;

  localparam int SW = 10;
  localparam int IW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alloc_valid = 1'b0;
  logic          alloc_ready;
  logic [SW-1:0] alloc_size = '0;
  logic [IW-1:0] alloc_index;
  logic          free_valid = 1'b0;
  logic [IW-1:0] free_index = '0;
  logic [SW-1:0] free_size = '0;
  logic [SW-1:0] free_space;

  cluster_pkt_ring_alloc dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .alloc_valid_i(alloc_valid),
    .alloc_ready_o(alloc_ready),
    .alloc_size_i (alloc_size),
    .alloc_index_o(alloc_index),
    .free_valid_i (free_valid),
    .free_index_i (free_index),
    .free_size_i  (free_size),
    .free_space_o (free_space)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    int    kind;   // 0 index, 1 free_space, 2 ready
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation tagged for the current cycle, away from the active edge.
  always @(negedge clk) begin
    int act;
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      case (e.kind)
        0:       act = int'(alloc_index);
        1:       act = int'(free_space);
        default: act = int'(alloc_ready);
      endcase
      if (e.cyc < cyc) begin
        n_err++;
        $display("FAIL %s: expectation for cycle %0d not checked in time", e.name, e.cyc);
      end else if (act != e.val) begin
        n_err++;
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", e.name, act, e.val, cyc);
      end
    end
  end

  function automatic void chk(input int kind, input int val, input string name);
    sb.push_back('{cyc, kind, val, name});
  endfunction

  task automatic step(input logic rst, input logic av, input int asz,
                      input logic fv, input int fidx, input int fsz);
    @(posedge clk);
    #1;
    rst_n       = rst;
    alloc_valid = av;
    alloc_size  = SW'(asz);
    free_valid  = fv;
    free_index  = IW'(fidx);
    free_size   = SW'(fsz);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 1'b0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    // Reset state
    step(1'b1, 1'b0, 512, 1'b0, 0, 0);
    chk(1, 512, "rst_space"); chk(0, 0, "rst_index"); chk(2, 1, "rst_ready_512");

    // 1: alloc 100 B
    step(1'b1, 1'b1, 100, 1'b0, 0, 0);
    chk(0, 0, "t1_index"); chk(1, 512, "t1_space_pre");
    step(1'b1, 1'b0, 0, 1'b0, 0, 0);
    chk(1, 384, "t1_space_post");

    // 2: wrap-around allocation
    do_reset();
    step(1'b1, 1'b1, 256, 1'b0, 0, 0);
    chk(0, 0, "t2_a256_index");
    step(1'b1, 1'b1, 64, 1'b0, 0, 0);
    chk(0, 256, "t2_a64_index"); chk(1, 256, "t2_space_a");
    step(1'b1, 1'b0, 0, 1'b1, 0, 256);
    chk(1, 192, "t2_space_prefree");
    step(1'b1, 1'b1, 256, 1'b0, 0, 0);
    chk(1, 256, "t2_space_postfree"); chk(0, 0, "t2_wrap_index"); chk(2, 1, "t2_wrap_ready");
    step(1'b1, 1'b0, 64, 1'b0, 0, 0);
    chk(1, 0, "t2_full_space"); chk(2, 0, "t2_full_ready");

    // 3: out-of-order free, then 5: same-cycle alloc and free
    do_reset();
    step(1'b1, 1'b1, 64, 1'b0, 0, 0);  chk(0, 0,   "t3_idx0");
    step(1'b1, 1'b1, 64, 1'b0, 0, 0);  chk(0, 64,  "t3_idx1");
    step(1'b1, 1'b1, 64, 1'b0, 0, 0);  chk(0, 128, "t3_idx2");
    step(1'b1, 1'b0, 0, 1'b1, 64, 64); chk(1, 320, "t3_space_3busy");
    step(1'b1, 1'b0, 0, 1'b1, 0, 64);  chk(1, 320, "t3_space_free64");
    step(1'b1, 1'b0, 0, 1'b1, 128, 64); chk(1, 320, "t3_space_free0");
    step(1'b1, 1'b1, 64, 1'b0, 0, 0);
    chk(1, 512, "t3_space_empty"); chk(0, 0, "t3_empty_index");
    step(1'b1, 1'b1, 64, 1'b1, 0, 64);
    chk(0, 64, "t5_index"); chk(1, 448, "t5_space_pre");
    step(1'b1, 1'b0, 0, 1'b0, 0, 0);
    chk(1, 384, "t5_space_post");

    // 4: zero-size requests
    do_reset();
    step(1'b1, 1'b1, 64, 1'b0, 0, 0);
    step(1'b1, 1'b1, 64, 1'b0, 0, 0);
    step(1'b1, 1'b1, 64, 1'b0, 0, 0);
    step(1'b1, 1'b1, 0, 1'b0, 0, 0);
    chk(0, 192, "t4_zero_index"); chk(1, 320, "t4_space"); chk(2, 1, "t4_zero_ready");
    step(1'b1, 1'b0, 0, 1'b1, 0, 0);
    chk(1, 320, "t4_space_after_zalloc"); chk(0, 192, "t4_index_after_zalloc");
    step(1'b1, 1'b0, 0, 1'b0, 0, 0);
    chk(1, 320, "t4_space_after_zfree");

    // 6: reset with 4 busy slots
    step(1'b1, 1'b1, 64, 1'b0, 0, 0);
    chk(0, 192, "t6_fourth_index");
    step(1'b0, 1'b1, 64, 1'b0, 0, 0);
    step(1'b1, 1'b0, 64, 1'b0, 0, 0);
    chk(1, 512, "t6_space"); chk(0, 0, "t6_index");

    // Boundaries: oversize, whole buffer, ignored request when full
    step(1'b1, 1'b0, 513, 1'b0, 0, 0); chk(2, 0, "bnd_513_ready");
    step(1'b1, 1'b1, 512, 1'b0, 0, 0); chk(2, 1, "bnd_512_ready"); chk(0, 0, "bnd_512_index");
    step(1'b1, 1'b1, 64, 1'b0, 0, 0);  chk(1, 0, "bnd_full_space"); chk(2, 0, "bnd_full_ready");
    step(1'b1, 1'b0, 0, 1'b1, 0, 512); chk(1, 0, "bnd_ignored_space");
    step(1'b1, 1'b0, 0, 1'b0, 0, 0);   chk(1, 512, "bnd_freed_space");

    step(1'b1, 1'b0, 0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 0, 1'b0, 0, 0);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
